// File: rtl/bus_fifo_regs.sv
// bus_fifo_regs: memory-mapped write FIFO on the decoded register bus.
// The host pushes words through DATA (offset 0).
// STATUS (offset 1) reports count, empty, full and a sticky overflow bit.
// CTRL (offset 2) holds the irq threshold and a self-clearing flush bit.
// Fabric logic drains the FIFO through the m_data/m_valid/m_ready stream.
// Optional feature macro: BUS_FIFO_IRQ_EN adds the registered level
// interrupt output irq.
module bus_fifo_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 16
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wr,
    input  logic        bus_rd,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
`ifdef BUS_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // Storage and state
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   thr_q, thr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    // Decode and handshake terms
    logic        hit;
    logic [1:0]  off;
    logic        wr_data, wr_status, wr_ctrl, rd_hit;
    logic        flush;
    logic        full, empty;
    logic        push_acc, push_drop, pop;
    logic [15:0] count16;
    logic [31:0] status_word;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus_addr[1:0];

    assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign off       = bus_addr[3:2];
    assign wr_data   = bus_wr && hit && (off == OFF_DATA);
    assign wr_status = bus_wr && hit && (off == OFF_STATUS);
    assign wr_ctrl   = bus_wr && hit && (off == OFF_CTRL);
    assign rd_hit    = bus_rd && hit;
    assign flush     = wr_ctrl && bus_wdata[16];

    // Full is judged on the pre-edge count, so a same-cycle pop never
    // makes room for a push. Flush discards any concurrent push or pop.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_acc  = wr_data && !full && !flush;
    assign push_drop = wr_data && full && !flush;
    assign pop       = m_valid && m_ready && !flush;

    assign count16     = 16'(count_q);
    assign status_word = {ovf_q, 13'd0, full, empty, count16};

    assign m_data     = mem_q[rd_ptr_q];
    assign m_valid    = !empty;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

    // Next-state for pointers, count, overflow, threshold and read-back
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        thr_d    = thr_q;
        rdata_d  = '0;
        rvalid_d = rd_hit;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_acc && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push_acc) count_d = count_q - 1'b1;
            if (push_drop)                      ovf_d = 1'b1;
            else if (wr_status && bus_wdata[31]) ovf_d = 1'b0;
        end

        if (wr_ctrl) thr_d = bus_wdata[15:0];

        // Read-back always reflects the state before this edge
        if (rd_hit) begin
            case (off)
                OFF_STATUS: rdata_d = status_word;
                OFF_CTRL:   rdata_d = {16'd0, thr_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    // Control state and registered read port
    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            thr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            thr_q    <= thr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // FIFO storage; contents are not reset, only the pointers are
    always_ff @(posedge aclk) begin
        if (push_acc) mem_q[wr_ptr_q] <= bus_wdata;
    end

`ifdef BUS_FIFO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ((count16 >= thr_q) && (thr_q != 16'd0)) || ovf_q;
    assign irq   = irq_q;

    // Interrupt level follows registered count/overflow by one cycle
    always_ff @(posedge aclk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
`endif

endmodule
